// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the word-copy DMA master.
package mem_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_e;

    localparam logic [3:0]  BE_FULL    = 4'hF;
    localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/mem_copy_master.sv
// Word-by-word memory copy master: one outstanding request,
// read then write per word, registered request outputs.
module mem_copy_master
    import mem_copy_pkg::*;
#(
    parameter int LenW = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [31:0]     src_addr_i,
    input  logic [31:0]     dst_addr_i,
    input  logic [LenW-1:0] len_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic            req_o,
    output logic            we_o,
    output logic [3:0]      be_o,
    output logic [31:0]     addr_o,
    output logic [31:0]     wdata_o,
    input  logic            gnt_i,
    input  logic [31:0]     rdata_i,
    input  logic            rvalid_i
);

    state_e          state_q;
    logic [31:0]     src_q;
    logic [31:0]     dst_q;
    logic [LenW-1:0] rem_q;
    logic [31:0]     data_q;
    logic [31:0]     addr_q;
    logic [3:0]      be_q;
    logic            req_q;
    logic            we_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;

    logic [31:0]     src_d;
    logic [31:0]     dst_d;
    logic [LenW-1:0] rem_d;
    logic            misaligned;

    assign src_d      = src_q + WORD_BYTES;
    assign dst_d      = dst_q + WORD_BYTES;
    assign rem_d      = rem_q - LenW'(1);
    assign misaligned = (src_addr_i[1:0] != 2'b00) ||
                        (dst_addr_i[1:0] != 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (misaligned) begin
                            err_q <= 1'b1;
                        end else if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            src_q   <= src_addr_i;
                            dst_q   <= dst_addr_i;
                            rem_q   <= len_i;
                            state_q <= S_RD_REQ;
                            req_q   <= 1'b1;
                            we_q    <= 1'b0;
                            be_q    <= BE_FULL;
                            addr_q  <= src_addr_i;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (gnt_i) begin
                        state_q <= S_RD_WAIT;
                        req_q   <= 1'b0;
                        be_q    <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (rvalid_i) begin
                        data_q  <= rdata_i;
                        state_q <= S_WR_REQ;
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        be_q    <= BE_FULL;
                        addr_q  <= dst_q;
                    end
                end
                S_WR_REQ: begin
                    if (gnt_i) begin
                        state_q <= S_WR_WAIT;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        be_q    <= '0;
                    end
                end
                S_WR_WAIT: begin
                    if (rvalid_i) begin
                        src_q <= src_d;
                        dst_q <= dst_d;
                        rem_q <= rem_d;
                        // Last word written: finish, else fetch the next one
                        if (rem_q == LenW'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_RD_REQ;
                            req_q   <= 1'b1;
                            be_q    <= BE_FULL;
                            addr_q  <= src_d;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // The captured word doubles as the write-data bus and holds between writes
    assign wdata_o = data_q;
    assign addr_o  = addr_q;
    assign be_o    = be_q;
    assign req_o   = req_q;
    assign we_o    = we_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: table vectors, corner
// sequences and random copies against a word-level copy model.
module tb_mem_copy_master;

    localparam int LenW = 16;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b0;
    logic            start_i = 1'b0;
    logic [31:0]     src_addr_i = '0;
    logic [31:0]     dst_addr_i = '0;
    logic [LenW-1:0] len_i = '0;
    logic            busy_o, done_o, err_o, req_o, we_o;
    logic [3:0]      be_o;
    logic [31:0]     addr_o, wdata_o;
    logic            gnt_i = 1'b1;
    logic [31:0]     rdata_i = '0;
    logic            rvalid_i = 1'b0;

    always #5 clk = ~clk;

    mem_copy_master #(.LenW(LenW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o),
        .addr_o(addr_o), .wdata_o(wdata_o),
        .gnt_i(gnt_i), .rdata_i(rdata_i), .rvalid_i(rvalid_i)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory contents: unwritten words read as an address hash
    logic [31:0] mem   [logic [31:0]];
    logic [31:0] model [logic [31:0]];

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction
    function automatic logic [31:0] rd_mem(logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction
    function automatic logic [31:0] rd_model(logic [31:0] a);
        return model.exists(a) ? model[a] : init_word(a);
    endfunction

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    wr_t expq[$];

    // Reference: ascending word copy, each write sees earlier writes
    task automatic model_copy(logic [31:0] s, logic [31:0] d, int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] sa, da, v;
            sa = s + 32'(4 * i);
            da = d + 32'(4 * i);
            v = rd_model(sa);
            model[da] = v;
            expq.push_back('{da, v});
        end
    endtask

    task automatic cmp_mem(string nm);
        bit bad = 0;
        foreach (model[a]) if (rd_mem(a) !== model[a]) bad = 1;
        foreach (mem[a]) if (mem[a] !== rd_model(a)) bad = 1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s memory image differs from copy model", nm);
        end
    endtask

    // Memory responder and bus monitor, all on the falling edge
    bit          rnd_gnt = 0;
    int          stall_left = 0;
    bit          inject_rv = 0;
    bit          pend = 0;
    logic [31:0] pend_d = '0;
    bit          prev_stall = 0;
    logic        p_we;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_wdata;
    int          rd_fires = 0;

    always @(negedge clk) begin
        rvalid_i = pend | inject_rv;
        rdata_i  = pend ? pend_d : $urandom;
        pend = 0;
        if (req_o && we_o && stall_left > 0) begin
            gnt_i = 1'b0;
            stall_left--;
        end else begin
            gnt_i = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (prev_stall) begin
            checks++;
            if (req_o !== 1'b1 || we_o !== p_we || be_o !== p_be ||
                addr_o !== p_addr || wdata_o !== p_wdata) begin
                errors++;
                $display("FAIL hold req=%b we=%b addr=%h wdata=%h required addr=%h wdata=%h",
                         req_o, we_o, addr_o, wdata_o, p_addr, p_wdata);
            end
        end
        prev_stall = req_o && !gnt_i;
        p_we = we_o; p_be = be_o; p_addr = addr_o; p_wdata = wdata_o;
        if (req_o && gnt_i) begin
            pend = 1;
            chk("req be", {28'd0, be_o}, 32'hF);
            if (we_o) begin
                mem[addr_o] = wdata_o;
                pend_d = $urandom;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL write unexpected addr %h data %h", addr_o, wdata_o);
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    if (e.a !== addr_o || e.d !== wdata_o) begin
                        errors++;
                        $display("FAIL write got %h:%h expected %h:%h",
                                 addr_o, wdata_o, e.a, e.d);
                    end
                end
            end else begin
                pend_d = rd_mem(addr_o);
                rd_fires++;
            end
        end
    end

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int          len;
        bit          rnd;
        int          stall;
        bit          poke;
        bit          exp_err;
        bit          chk_cyc;
    } vec_t;

    task automatic run_vec(vec_t v, string nm);
        int  c0;
        bit  seen = 0;
        bit  busy_bad = 0;
        bit  go;
        go = !v.exp_err && v.len > 0;
        if (go) model_copy(v.src, v.dst, v.len);
        rnd_gnt = v.rnd;
        stall_left = v.stall;
        @(negedge clk);
        start_i = 1'b1;
        src_addr_i = v.src;
        dst_addr_i = v.dst;
        len_i = LenW'(v.len);
        c0 = cyc;
        @(negedge clk);
        start_i = 1'b0;
        chk({nm, " err"}, 32'(err_o), 32'(v.exp_err));
        chk({nm, " busy"}, 32'(busy_o), 32'(go));
        if (v.exp_err) begin
            chk({nm, " noreq"}, 32'(req_o), 0);
            @(negedge clk);
            chk({nm, " errpulse"}, 32'(err_o), 0);
            chk({nm, " busy2"}, 32'(busy_o | req_o), 0);
            return;
        end
        for (int i = 0; i < 4000 && !seen; i++) begin
            if (done_o) begin
                seen = 1;
            end else begin
                if (busy_o !== 1'b1) busy_bad = 1;
                if (v.poke && i == 5) begin
                    start_i = 1'b1;
                    src_addr_i = v.src + 32'h40;
                    dst_addr_i = v.dst + 32'h80;
                    len_i = LenW'(v.len + 3);
                end else begin
                    start_i = 1'b0;
                end
                @(negedge clk);
            end
        end
        start_i = 1'b0;
        chk({nm, " done seen"}, 32'(seen), 1);
        if (!seen) return;
        if (v.chk_cyc) chk({nm, " cycles"}, 32'(cyc - c0), 32'(4 * v.len + 1));
        chk({nm, " busy at done"}, 32'(busy_o), 0);
        chk({nm, " busy during"}, 32'(busy_bad), 0);
        @(negedge clk);
        chk({nm, " done pulse"}, 32'(done_o), 0);
        chk({nm, " pending"}, 32'(expq.size()), 0);
        cmp_mem(nm);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'h100, 32'h200, 3, 0, 0, 0, 0, 1};
        vecs[1] = '{32'h2000, 32'h2004, 4, 0, 0, 0, 0, 1};
        vecs[2] = '{32'hFFFF_FFFC, 32'h300, 2, 0, 0, 0, 0, 1};
        vecs[3] = '{32'h0, 32'h500, 0, 0, 0, 0, 0, 1};
        vecs[4] = '{32'h102, 32'h200, 2, 0, 0, 0, 1, 0};
        vecs[5] = '{32'h100, 32'h203, 1, 0, 0, 0, 1, 0};
        vecs[6] = '{32'h400, 32'h800, 5, 1, 0, 0, 0, 0};
        vecs[7] = '{32'h600, 32'h700, 2, 0, 5, 0, 0, 0};
        vecs[8] = '{32'h900, 32'hA00, 3, 0, 0, 1, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy_o), 0);
        chk("reset req", 32'(req_o | we_o | done_o | err_o), 0);
        chk("reset be", 32'(be_o), 0);
        chk("reset addr", addr_o, 0);
        chk("reset wdata", wdata_o, 0);
        rst_ni = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort during the second read's wait, then a clean copy
        model_copy(32'hC00, 32'hD00, 1);
        rnd_gnt = 0;
        stall_left = 0;
        rd_fires = 0;
        @(negedge clk);
        start_i = 1'b1;
        src_addr_i = 32'hC00;
        dst_addr_i = 32'hD00;
        len_i = LenW'(4);
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i < 50 && rd_fires < 2; i++) @(negedge clk);
        chk("abort reached rd2", 32'(rd_fires), 2);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        chk("abort busy", 32'(busy_o), 0);
        chk("abort req", 32'(req_o | we_o | done_o | err_o), 0);
        chk("abort be", 32'(be_o), 0);
        chk("abort addr", addr_o, 0);
        chk("abort wdata", wdata_o, 0);
        @(negedge clk);
        rst_ni = 1'b1;
        inject_rv = 1;
        @(negedge clk);
        inject_rv = 0;
        @(negedge clk);
        chk("post abort idle", 32'(busy_o | req_o | done_o), 0);
        chk("abort pending", 32'(expq.size()), 0);
        cmp_mem("abort");
        run_vec('{32'hC40, 32'hD40, 2, 0, 0, 0, 0, 1}, "after abort");

        for (int n = 0; n < 25; n++) begin
            vec_t r;
            r.src = 32'h4000 + 32'($urandom_range(0, 63) * 4);
            r.dst = 32'h4000 + 32'($urandom_range(0, 63) * 4);
            if ($urandom_range(0, 7) == 0) r.src[1] = 1'b1;
            if ($urandom_range(0, 7) == 0) r.dst[0] = 1'b1;
            r.len = $urandom_range(0, 6);
            r.rnd = 1;
            r.stall = $urandom_range(0, 3);
            r.poke = 0;
            r.exp_err = (r.src[1:0] != 2'b00) || (r.dst[1:0] != 2'b00);
            r.chk_cyc = 0;
            run_vec(r, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
